// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signal bundle for the round-robin FIFO write arbiter.
// Latency: none, wiring only.
// Backpressure: producers hold req until they see gnt; the FIFO side reports full/empty/ack/overflow.
//
// Ports (master = arbiter side):
//   req, req_data     producer requests and packed data words (in)
//   gnt               one-hot accept back to the producers (out)
//   fifo_wr_en/_data_in  registered FIFO write port (out)
//   fifo_rd_en, fifo_full, fifo_empty, fifo_wr_ack, fifo_overflow  FIFO status (in)
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_rd_en;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;

    modport master (
        input  req, req_data, fifo_rd_en, fifo_full, fifo_empty, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output req, req_data, fifo_rd_en, fifo_full, fifo_empty, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, with flush and error tracking.
// Latency: gnt is combinational; the accepted word reaches fifo_wr_en/fifo_data_in one cycle later.
// Backpressure: no grant while credits==0, fifo_full, flushing or disabled; producers hold req until gnt.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   enable            0 blocks new grants
//   flush_req         start a drain: stop granting, wait for an empty FIFO, pulse flush_done
//   flush_done        one-cycle pulse when the drain completes
//   credits           free FIFO entries as seen by the arbiter
//   busy              flushing or a write is in flight
//   ack_err           sticky: missing wr_ack, FIFO overflow, or a read with credits already full
//   bus               producer/FIFO handshake bundle (master modport)
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          flush_req,
    output logic          flush_done,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          ack_err,
    fifo_wr_arbiter_if.master bus
);

    typedef enum logic [1:0] {RUN, PAUSE, DONE} state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

    state_t                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic                  grant;
    logic                  rd;
    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [DATA_WIDTH-1:0] data_q;

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // rst_n gates the grant so gnt drops the instant reset asserts, not at the next edge.
    assign grant = rst_n && (state == RUN) && enable && !flush_req &&
                   (credits != '0) && !bus.fifo_full && found;

    assign bus.gnt = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;

    // A read only frees an entry when the FIFO actually had one to give.
    assign rd = bus.fifo_rd_en && !bus.fifo_empty;

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign busy             = (state != RUN) || wr_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            rr_ptr     <= '0;
            credits    <= CRED_MAX;
            wr_en_q    <= 1'b0;
            wr_en_d    <= 1'b0;
            data_q     <= '0;
            flush_done <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            wr_en_q <= grant;
            wr_en_d <= wr_en_q;
            if (grant) begin
                data_q <= bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                if (int'(winner) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= winner + 1'b1;
                end
            end

            // Credits are taken at grant time, not write time, so the in-flight word is covered.
            if (grant && !rd) begin
                credits <= credits - 1'b1;
            end else if (rd && !grant && credits != CRED_MAX) begin
                credits <= credits + 1'b1;
            end

            // The FIFO acks one cycle after it sees wr_en, hence the delayed copy.
            if ((wr_en_d && !bus.fifo_wr_ack) || bus.fifo_overflow ||
                (rd && !grant && credits == CRED_MAX)) begin
                ack_err <= 1'b1;
            end

            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (credits == CRED_MAX && bus.fifo_empty && !wr_en_q) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based FIFO and scoreboard.
// Latency: checks combinational gnt on the falling edge, registered outputs one cycle after the grant edge.
// Backpressure: producers hold req/data until granted; consumer reads randomly through a depth-8 FIFO model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] credits;
    logic          busy;
    logic          ack_err;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .credits    (credits),
        .busy       (busy),
        .ack_err    (ack_err),
        .bus        (bus)
    );

    // ---------------- FIFO model (depth 8, registered wr_ack/overflow) ----------------
    logic [DW-1:0] fmem [DEPTH];
    int            fcnt, frp, fwp, ovf_seen;
    logic          ack_q, ovf_q, kill_ack, force_ovf;
    logic          f_wr, f_rd;

    assign f_wr              = bus.fifo_wr_en && (fcnt != DEPTH);
    assign f_rd              = bus.fifo_rd_en && (fcnt != 0);
    assign bus.fifo_full     = (fcnt == DEPTH);
    assign bus.fifo_empty    = (fcnt == 0);
    assign bus.fifo_wr_ack   = ack_q && !kill_ack;
    assign bus.fifo_overflow = ovf_q || force_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= 0;
            frp   <= 0;
            fwp   <= 0;
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= f_wr;
            ovf_q <= bus.fifo_wr_en && (fcnt == DEPTH);
            if (f_wr) begin
                fmem[fwp] <= bus.fifo_data_in;
                fwp       <= (fwp + 1) % DEPTH;
            end
            if (f_rd) frp <= (frp + 1) % DEPTH;
            fcnt <= fcnt + int'(f_wr) - int'(f_rd);
        end
    end

    always @(posedge clk) if (ovf_q) ovf_seen <= ovf_seen + 1;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: 0=running 1=draining 2=drain-complete ----------------
    int               m_state, m_ptr, m_cred, m_wr_en, m_data, m_err, m_wr_prev;
    int               exp_q[$];
    logic [NUM_REQ-1:0] dut_gnt;
    logic             last_done;
    int               done_pulses;

    task automatic m_reset();
        m_state = 0; m_ptr = 0; m_cred = DEPTH; m_wr_en = 0; m_data = 0;
        m_err = 0; m_wr_prev = 0; exp_q.delete();
    endtask

    // One clock: check everything on the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        int can, win, egnt, rdv, n_state, n_cred, n_err_f;
        @(negedge clk);
        rdv = (bus.fifo_rd_en && !bus.fifo_empty) ? 1 : 0;
        win = -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (win < 0 && bus.req[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        can  = (m_state == 0 && enable && !flush_req && m_cred > 0 && !bus.fifo_full && win >= 0) ? 1 : 0;
        egnt = can ? (1 << win) : 0;

        dut_gnt   = bus.gnt;
        last_done = flush_done;
        check("gnt", bus.gnt, egnt);
        check("wr_en", bus.fifo_wr_en, m_wr_en);
        check("data_in", bus.fifo_data_in, m_data);
        check("credits", credits, m_cred);
        check("flush_done", flush_done, (m_state == 2) ? 1 : 0);
        check("ack_err", ack_err, m_err);
        check("busy", busy, (m_state != 0 || m_wr_en != 0) ? 1 : 0);
        if (m_state == 2) done_pulses++;
        if (rdv) begin
            if (exp_q.size() == 0) check("rd_underrun", 1, 0);
            else check("rd_data", fmem[frp], exp_q.pop_front());
        end

        n_cred = m_cred;
        n_err_f = m_err;
        if (can && !rdv) n_cred = m_cred - 1;
        if (rdv && !can) begin
            if (m_cred == DEPTH) n_err_f = 1;
            else n_cred = m_cred + 1;
        end
        if ((m_wr_prev && !bus.fifo_wr_ack) || bus.fifo_overflow) n_err_f = 1;
        n_state = m_state;
        if (m_state == 0 && flush_req) n_state = 1;
        else if (m_state == 1 && m_cred == DEPTH && bus.fifo_empty && !m_wr_en) n_state = 2;
        else if (m_state == 2) n_state = 0;

        @(posedge clk);
        #1;
        m_wr_prev = m_wr_en;
        m_wr_en   = can;
        if (can) begin
            m_data = int'(bus.req_data[win*DW +: DW]);
            m_ptr  = (win + 1) % NUM_REQ;
            exp_q.push_back(m_data);
        end
        m_cred  = n_cred;
        m_err   = n_err_f;
        m_state = n_state;
    endtask

    // New data only for requesters that were just granted or are newly raised.
    task automatic set_req(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++)
            if (mask[i] && (!bus.req[i] || dut_gnt[i])) bus.req_data[i*DW +: DW] = DW'($urandom);
        bus.req = mask;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_data", bus.fifo_data_in, 0);
        check("rst_credits", credits, DEPTH);
        check("rst_ack_err", ack_err, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req = '0; enable = 1'b0; flush_req = 1'b0; bus.fifo_rd_en = 1'b0;
        kill_ack = 1'b0; force_ovf = 1'b0; dut_gnt = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pause_gnts, done_seen;
        logic [NUM_REQ-1:0] nm;
        bus.req = '0; bus.req_data = '0; bus.fifo_rd_en = 1'b0;
        enable = 1'b0; flush_req = 1'b0; kill_ack = 1'b0; force_ovf = 1'b0;
        dut_gnt = '0; ovf_seen = 0; done_pulses = 0; last_done = 1'b0;
        #2 do_reset();

        // Saturation: all four requesting, no reads.
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_req(4'b1111);
            cycle();
            if (c < 8) check("sat_gnt", dut_gnt, 1 << (c % 4));
            else       check("sat_idle", dut_gnt, 0);
        end
        check("sat_credits", credits, 0);
        check("sat_full", bus.fifo_full, 1);
        check("sat_no_ovf", ovf_seen, 0);

        // Zero credits with a read and a request: grant waits one cycle.
        bus.fifo_rd_en = 1'b1;
        set_req(4'b1111);
        cycle();
        check("zero_cred_gnt", dut_gnt, 0);
        check("zero_cred_inc", credits, 1);
        set_req(4'b1111);
        cycle();
        check("zero_cred_next", (dut_gnt != 0), 1);
        set_req(4'b0000);
        repeat (12) cycle();
        check("drain_credits", credits, DEPTH);

        // Reset during active grants, then fairness.
        set_req(4'b1111);
        repeat (3) cycle();
        do_reset();
        enable = 1'b1; bus.fifo_rd_en = 1'b1;
        set_req(4'b1111); cycle();
        check("rst_first_gnt", dut_gnt, 4'b0001);
        set_req(4'b0010); cycle();
        check("fair_prime", dut_gnt, 4'b0010);
        for (int c = 0; c < 4; c++) begin
            set_req(4'b1010); cycle();
            check("fair_alt", dut_gnt, (c % 2 == 0) ? 4'b1000 : 4'b0010);
        end
        for (int c = 0; c < 4; c++) begin
            set_req(4'b0001); cycle();
            check("fair_single", dut_gnt, 4'b0001);
        end

        // Grant and read in the same cycle at credits=3.
        do_reset();
        enable = 1'b1;
        repeat (5) begin set_req(4'b0001); cycle(); end
        check("simul_pre", credits, 3);
        bus.fifo_rd_en = 1'b1;
        set_req(4'b0001); cycle();
        check("simul_gnt", dut_gnt, 4'b0001);
        check("simul_cred", credits, 3);

        // Flush: 5 words, flush pulse, consumer drains.
        do_reset();
        enable = 1'b1;
        repeat (5) begin set_req(4'b0001); cycle(); end
        set_req(4'b0000); cycle();
        flush_req = 1'b1; set_req(4'b1111); cycle();
        check("flush_req_gnt", dut_gnt, 0);
        flush_req = 1'b0; bus.fifo_rd_en = 1'b1;
        pause_gnts = 0; done_seen = 0; done_pulses = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            set_req(4'b1111); cycle();
            if (last_done) done_seen = 1;
            else if (dut_gnt != 0) pause_gnts++;
        end
        check("flush_done_seen", done_seen, 1);
        check("flush_no_gnt", pause_gnts, 0);
        set_req(4'b1111); cycle();
        check("flush_resume", (dut_gnt != 0), 1);
        check("flush_one_pulse", done_pulses, 1);

        // Missing wr_ack is sticky until reset.
        do_reset();
        enable = 1'b1;
        set_req(4'b0001); cycle();
        set_req(4'b0000); cycle();
        kill_ack = 1'b1; cycle();
        kill_ack = 1'b0; cycle();
        check("ack_err_set", ack_err, 1);
        repeat (5) cycle();
        check("ack_err_sticky", ack_err, 1);
        do_reset();
        force_ovf = 1'b1; cycle();
        force_ovf = 1'b0; cycle();
        check("ovf_err_set", ack_err, 1);

        // Random traffic, with one reset in the middle.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            for (int i = 0; i < NUM_REQ; i++)
                nm[i] = (!bus.req[i] || dut_gnt[i]) ? ($urandom_range(3) != 0) : 1'b1;
            set_req(nm);
            enable         = ($urandom_range(9) != 0);
            bus.fifo_rd_en = $urandom_range(1) != 0;
            flush_req      = ($urandom_range(29) == 0);
            cycle();
        end
        flush_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the synchronous FIFO (depth 8) between NUM_REQ producers. Uses a credit counter that mirrors FIFO occupancy, so the FIFO is never written while full and overflow cannot occur. Provides a flush sequence (stop granting, wait for drain, pulse done) and a sticky error flag fed by the FIFO's wr_ack and overflow status. Sits between the producer agents and the FIFO DUT; the FIFO consumer drives rd_en directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, FIFO data width
FIFO_DEPTH, 8, FIFO entries; initial and maximum credit value

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  arbitration enable; 0 = no new grants
req  in  NUM_REQ  per-requester valid; held until granted
req_data  in  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-hot combinational accept; req_data[i] captured at this edge
flush_req  in  1  request drain of the FIFO
flush_done  out  1  one-cycle pulse when the drain completes
fifo_wr_en  out  1  registered FIFO write enable
fifo_data_in  out  DATA_WIDTH  registered FIFO write data
fifo_rd_en  in  1  consumer's rd_en to the FIFO, monitored only
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
fifo_wr_ack  in  1  FIFO wr_ack
fifo_overflow  in  1  FIFO overflow
credits  out  $clog2(FIFO_DEPTH+1)  free FIFO entries as tracked by the arbiter
busy  out  1  state!=RUN or fifo_wr_en
ack_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): gnt=0, fifo_wr_en=0, fifo_data_in=0, credits=FIFO_DEPTH, rr pointer=0, state=RUN, flush_done=0, ack_err=0. Asserting reset mid-operation discards all in-flight state immediately.
- States: RUN, PAUSE, DONE.
  - RUN -> PAUSE when flush_req=1. No grant in the cycle flush_req is sampled high.
  - PAUSE -> DONE when credits==FIFO_DEPTH && fifo_empty && !fifo_wr_en.
  - DONE -> RUN unconditionally. flush_done=1 only while in DONE.
  - flush_req is ignored in PAUSE and DONE.
- Grant condition (combinational): state==RUN && enable && !flush_req && credits!=0 && !fifo_full && |req.
  - Winner is the first set req at or after the rr pointer, wrapping modulo NUM_REQ.
  - gnt is one-hot on the winner and all-zero otherwise.
- On a grant edge:
  - fifo_wr_en<=1 and fifo_data_in<=req_data[winner], so there is one cycle of latency from accept to FIFO write.
  - rr pointer <= (winner+1) mod NUM_REQ.
  - With no grant, fifo_wr_en<=0 and fifo_data_in holds its value.
- Credits: rd = fifo_rd_en && !fifo_empty.
  - grant && !rd: decrement.
  - rd && !grant: increment, saturating at FIFO_DEPTH; an increment attempted at FIFO_DEPTH sets ack_err.
  - grant && rd: unchanged.
  - A grant never occurs at credits==0.
- ack_err (sticky until reset) is set when either:
  - fifo_wr_en was 1 in the previous cycle and fifo_wr_ack==0 now, or
  - fifo_overflow==1.
- Requester rule: req[i] plus stable req_data stay asserted until gnt[i]. The requester may keep req high after a grant to present its next word.
- Throughput: one write per cycle maximum. A single continuous requester is granted every cycle while credits allow.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles during active grants -> gnt=0, fifo_wr_en=0, credits=8, ack_err=0, flush_done=0 asynchronously; first grant after release goes to req[0].
- Saturation: req=4'b1111 held, fifo_rd_en=0 -> gnt sequence 0,1,2,3,0,1,2,3 over 8 consecutive cycles, then gnt=0; credits=0; fifo_full=1; fifo_overflow never set; FIFO data matches requester order.
- Fairness: last grant to requester 1, then req=4'b1010 held -> grants 3,1,3,1; with req=4'b0001 only -> requester 0 granted every cycle.
- Simultaneous: credits=3, one grant plus one valid read in the same cycle -> credits stays 3. At credits=0 with rd=1 and req=1 -> no grant that cycle, credits=1, grant the next cycle.
- Flush: 5 words written, pulse flush_req, consumer reads 5 -> no gnt from the flush_req cycle on; flush_done high for exactly one cycle after credits==8 && fifo_empty; grants resume the next cycle.
- Error: force fifo_wr_ack=0 in the cycle after one fifo_wr_en -> ack_err=1 and stays 1 until rst_n=0; separately, force fifo_overflow=1 -> ack_err=1.
